// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store request at a time, waits a
// fixed number of cycles, performs the access on a little-endian word array
// and presents a registered response until the initiator takes it.
module dmem_responder #(
  parameter int ADDR_W = 20,
  parameter int WAIT   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int         WORDS    = 2 ** (ADDR_W - 2);
  localparam logic [3:0] CNT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [WORDS];

  logic              accept;
  logic              access;
  logic              useIn;
  logic              accWe;
  logic [1:0]        accSize;
  logic              accUns;
  logic [31:0]       accAddr;
  logic [31:0]       accWdata;
  logic [ADDR_W-3:0] wIdx;
  logic [31:0]       rdWord;
  logic [7:0]        rdByte;
  logic [15:0]       rdHalf;
  logic [31:0]       loadData;
  logic              sizeErr;
  logic              rangeErr;
  logic              accErr;
  logic [31:0]       wLanes;
  logic [3:0]        byteEn;
  logic              memWrite;

  assign accept = (state_q == ST_IDLE) && req_valid_i;
  // With no wait cycles the access happens on the accept edge itself, so the
  // live request inputs feed the access path instead of the captured copy.
  assign access = (WAIT == 0) ? accept : ((state_q == ST_WAIT) && (cnt_q == 4'd0));
  assign useIn  = (state_q == ST_IDLE);

  assign accWe    = useIn ? req_we_i       : we_q;
  assign accSize  = useIn ? req_size_i     : size_q;
  assign accUns   = useIn ? req_unsigned_i : uns_q;
  assign accAddr  = useIn ? req_addr_i     : addr_q;
  assign accWdata = useIn ? req_wdata_i    : wdata_q;

  assign wIdx   = accAddr[ADDR_W-1:2];
  assign rdWord = mem[wIdx];

  // Classify the request: alignment per size, illegal size, address range.
  always_comb begin
    sizeErr = 1'b0;
    case (accSize)
      2'b00:   sizeErr = 1'b0;
      2'b01:   sizeErr = accAddr[0];
      2'b10:   sizeErr = |accAddr[1:0];
      default: sizeErr = 1'b1;
    endcase
    rangeErr = |(accAddr >> ADDR_W);
    accErr   = sizeErr || rangeErr;
  end

  // Pick the addressed byte/half out of the word and extend it.
  always_comb begin
    rdByte   = rdWord[8*accAddr[1:0] +: 8];
    rdHalf   = accAddr[1] ? rdWord[31:16] : rdWord[15:0];
    loadData = rdWord;
    case (accSize)
      2'b00:   loadData = accUns ? {24'd0, rdByte} : {{24{rdByte[7]}}, rdByte};
      2'b01:   loadData = accUns ? {16'd0, rdHalf} : {{16{rdHalf[15]}}, rdHalf};
      default: loadData = rdWord;
    endcase
  end

  // Replicate store data onto every lane and enable only the addressed ones.
  always_comb begin
    wLanes = accWdata;
    byteEn = 4'hF;
    case (accSize)
      2'b00: begin
        wLanes = {4{accWdata[7:0]}};
        byteEn = 4'b0001 << accAddr[1:0];
      end
      2'b01: begin
        wLanes = {2{accWdata[15:0]}};
        byteEn = 4'b0011 << accAddr[1:0];
      end
      default: begin
        wLanes = accWdata;
        byteEn = 4'hF;
      end
    endcase
    memWrite = access && accWe && !accErr;
  end

  // Memory array has no reset; only legal stores ever modify it.
  always_ff @(posedge clk) begin
    if (memWrite) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEn[b]) begin
          mem[wIdx][8*b +: 8] <= wLanes[8*b +: 8];
        end
      end
    end
  end

  // Next-state, wait counter, request capture and response register values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          we_d    = req_we_i;
          size_d  = req_size_i;
          uns_d   = req_unsigned_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          cnt_d   = CNT_INIT;
          state_d = (WAIT > 0) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (access) begin
      rdata_d = (accErr || accWe) ? 32'd0 : loadData;
      err_d   = accErr;
    end
  end

  // Control and response state registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a WAIT=2 instance for the main sequence and a
// WAIT=0 instance for the zero-wait latency and range check.
module tb_dmem_responder;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        sel;
  logic        reqValid;
  logic        reqWe;
  logic [1:0]  reqSize;
  logic        reqUns;
  logic [31:0] reqAddr;
  logic [31:0] reqWdata;
  logic        rspReady;

  logic        reqReady0, rspValid0, rspErr0;
  logic [31:0] rspRdata0;
  logic        reqReady1, rspValid1, rspErr1;
  logic [31:0] rspRdata1;

  logic        reqReady, rspValid, rspErr;
  logic [31:0] rspRdata;

  exp_t sb[$];
  int   total;
  int   bad;

  dmem_responder #(.ADDR_W(20), .WAIT(2)) dut0 (
    .clk            (clk),
    .reset          (reset),
    .req_valid_i    (reqValid & ~sel),
    .req_ready_o    (reqReady0),
    .req_we_i       (reqWe),
    .req_size_i     (reqSize),
    .req_unsigned_i (reqUns),
    .req_addr_i     (reqAddr),
    .req_wdata_i    (reqWdata),
    .rsp_valid_o    (rspValid0),
    .rsp_ready_i    (rspReady & ~sel),
    .rsp_rdata_o    (rspRdata0),
    .rsp_err_o      (rspErr0)
  );

  dmem_responder #(.ADDR_W(20), .WAIT(0)) dut1 (
    .clk            (clk),
    .reset          (reset),
    .req_valid_i    (reqValid & sel),
    .req_ready_o    (reqReady1),
    .req_we_i       (reqWe),
    .req_size_i     (reqSize),
    .req_unsigned_i (reqUns),
    .req_addr_i     (reqAddr),
    .req_wdata_i    (reqWdata),
    .rsp_valid_o    (rspValid1),
    .rsp_ready_i    (rspReady & sel),
    .rsp_rdata_o    (rspRdata1),
    .rsp_err_o      (rspErr1)
  );

  assign reqReady = sel ? reqReady1 : reqReady0;
  assign rspValid = sel ? rspValid1 : rspValid0;
  assign rspErr   = sel ? rspErr1   : rspErr0;
  assign rspRdata = sel ? rspRdata1 : rspRdata0;

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present a request at a falling edge and return on the falling edge of
  // the first cycle after it was accepted.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    reqWe    = we;
    reqSize  = size;
    reqUns   = uns;
    reqAddr  = addr;
    reqWdata = wdata;
    reqValid = 1'b1;
    n = 0;
    while (!reqReady && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", {31'd0, reqReady}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
  endtask

  // Count cycles from accept until rsp_valid, bounded.
  task automatic waitValid(input string tag);
    int lat;
    lat = 1;
    while (!rspValid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), sel ? 32'd1 : 32'd3);
  endtask

  // Pop the oldest expectation and compare it with the presented response.
  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      check({e.tag, "_valid"}, {31'd0, rspValid}, 32'd1);
      check({e.tag, "_rdata"}, rspRdata, e.rdata);
      check({e.tag, "_err"}, {31'd0, rspErr}, {31'd0, e.err});
    end
  endtask

  task automatic handshake();
    rspReady = 1'b1;
    @(negedge clk);
    rspReady = 1'b0;
  endtask

  task automatic doTxn(input string tag, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] expRdata, input logic expErr);
    exp_t e;
    e.tag   = tag;
    e.rdata = expRdata;
    e.err   = expErr;
    sb.push_back(e);
    applyStimulus(we, size, uns, addr, wdata);
    waitValid(tag);
    checkOutput();
    handshake();
  endtask

  initial begin
    exp_t e;
    total    = 0;
    bad      = 0;
    sel      = 1'b0;
    reset    = 1'b0;
    reqValid = 1'b0;
    reqWe    = 1'b0;
    reqSize  = 2'b00;
    reqUns   = 1'b0;
    reqAddr  = 32'd0;
    reqWdata = 32'd0;
    rspReady = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_rsp_valid", {31'd0, rspValid}, 32'd0);
    check("rst_rdata", rspRdata, 32'd0);
    check("rst_err", {31'd0, rspErr}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_req_ready", {31'd0, reqReady}, 32'd1);
    check("rst_rsp_valid_after", {31'd0, rspValid}, 32'd0);

    // Word store and load back.
    doTxn("st_w_100", 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0);
    doTxn("ld_w_100", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0);

    // Byte store, signed/unsigned byte loads, merged word.
    doTxn("st_b_101", 1'b1, 2'b00, 1'b0, 32'h101, 32'h00000080, 32'h0, 1'b0);
    doTxn("ld_bs_101", 1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 32'hFFFFFF80, 1'b0);
    doTxn("ld_bu_101", 1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 32'h00000080, 1'b0);
    doTxn("ld_w_100b", 1'b0, 2'b10, 1'b1, 32'h100, 32'h0, 32'hDEAD80EF, 1'b0);

    // Halfword loads, misaligned accesses, illegal size, range.
    doTxn("ld_hs_102", 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'hFFFFDEAD, 1'b0);
    doTxn("ld_h_101", 1'b0, 2'b01, 1'b0, 32'h101, 32'h0, 32'h0, 1'b1);
    doTxn("st_w_4", 1'b1, 2'b10, 1'b0, 32'h4, 32'h0BADF00D, 32'h0, 1'b0);
    doTxn("st_w_5", 1'b1, 2'b10, 1'b0, 32'h5, 32'h11111111, 32'h0, 1'b1);
    doTxn("ld_w_4", 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h0BADF00D, 1'b0);
    doTxn("ld_sz11", 1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1);
    doTxn("ld_range", 1'b0, 2'b10, 1'b0, 32'h00100000, 32'h0, 32'h0, 1'b1);
    doTxn("st_w_104", 1'b1, 2'b10, 1'b0, 32'h104, 32'h11223344, 32'h0, 1'b0);
    doTxn("st_h_106", 1'b1, 2'b01, 1'b0, 32'h106, 32'h0000A5C3, 32'h0, 1'b0);
    doTxn("ld_w_104", 1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 32'hA5C33344, 1'b0);
    doTxn("ld_hu_106", 1'b0, 2'b01, 1'b1, 32'h106, 32'h0, 32'h0000A5C3, 1'b0);

    // Hold the response for five cycles while a competing request is offered.
    e.tag   = "hold_ld_100";
    e.rdata = 32'hDEAD80EF;
    e.err   = 1'b0;
    sb.push_back(e);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    waitValid("hold_ld_100");
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", {31'd0, rspValid}, 32'd1);
      check("hold_rdata", rspRdata, 32'hDEAD80EF);
      check("hold_err", {31'd0, rspErr}, 32'd0);
      check("hold_req_ready", {31'd0, reqReady}, 32'd0);
      if (i == 0) begin
        reqWe    = 1'b1;
        reqSize  = 2'b10;
        reqAddr  = 32'h104;
        reqWdata = 32'hFFFFFFFF;
        reqValid = 1'b1;
      end
      @(negedge clk);
    end
    checkOutput();
    reqValid = 1'b0;
    handshake();
    doTxn("ld_w_104_kept", 1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 32'hA5C33344, 1'b0);

    // Reset one cycle after accepting a store abandons it.
    doTxn("st_w_200", 1'b1, 2'b10, 1'b0, 32'h200, 32'hCAFEF00D, 32'h0, 1'b0);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h200, 32'h12345678);
    reset = 1'b0;
    @(negedge clk);
    check("rstwait_rsp_valid", {31'd0, rspValid}, 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rstwait_no_rsp", {31'd0, rspValid}, 32'd0);
    end
    check("rstwait_req_ready", {31'd0, reqReady}, 32'd1);
    doTxn("ld_w_200", 1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 32'hCAFEF00D, 1'b0);

    // Zero-wait instance.
    sel = 1'b1;
    @(negedge clk);
    doTxn("w0_range", 1'b0, 2'b10, 1'b0, 32'h00100000, 32'h0, 32'h0, 1'b1);
    doTxn("w0_st_10", 1'b1, 2'b10, 1'b0, 32'h10, 32'h55AA55AA, 32'h0, 1'b0);
    doTxn("w0_ld_bs_13", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'h00000055, 1'b0);
    doTxn("w0_ld_w_10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h55AA55AA, 1'b0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter ADDR_W, default 20, byte-address width of the memory (2^ADDR_W bytes, 2^(ADDR_W-2) 32-bit words).
REQ-002 Parameter WAIT, default 2, wait cycles inserted between request accept and memory access (0..15).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  block accepts a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-009 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-010 req_addr  input  32  byte address.
REQ-011 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 rsp_valid  output  1  response present.
REQ-013 rsp_ready  input  1  initiator takes the response.
REQ-014 rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-015 rsp_err  output  1  request rejected (misaligned, illegal size, out of range).

Function
REQ-016 FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-017 IDLE: req_valid=1 captures we/size/unsigned/addr/wdata; next state WAIT if WAIT>0, else RESP.
REQ-018 WAIT: counter loads WAIT-1 on accept, decrements each cycle; at 0, access performed, next state RESP.
REQ-019 Accept-to-rsp_valid latency exactly WAIT+1 cycles.
REQ-020 Access (on the RESP-entry edge) commits the store or samples the load into a registered response; rsp_rdata/rsp_err stable throughout RESP.
REQ-021 RESP: rsp_valid=1; rsp_ready=1 returns to IDLE next edge; rsp_ready=0 holds RESP and response unchanged.
REQ-022 No back-to-back acceptance: new request accepted no earlier than the cycle after the handshake; throughput one request per WAIT+2 cycles.
REQ-023 Little-endian: byte k of a word at addr[1:0]=k in bits [8k+7:8k].
REQ-024 Byte store writes only the addressed byte; halfword store writes bytes addr[1:0] and addr[1:0]+1; word store writes all four.
REQ-025 Byte load returns the addressed byte, halfword load the addressed half, each extended to 32 bits per req_unsigned; word load ignores req_unsigned.
REQ-026 Error when size=11, size=01 with addr[0]=1, size=10 with addr[1:0]!=0, or req_addr >= 2^ADDR_W.
REQ-027 On error: no memory modification, rsp_err=1, rsp_rdata=0, same latency as a legal request.
REQ-028 Stores respond with rsp_err per REQ-026, rsp_rdata=0.
REQ-029 req_* inputs ignored outside IDLE; changes while busy have no effect.

Reset
REQ-030 reset=0: state IDLE, counter 0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=1 once reset deasserts.
REQ-031 Reset during WAIT abandons the request; uncommitted store never written; no response issued.
REQ-032 Reset during RESP drops the response; already committed store remains.
REQ-033 Memory contents unaffected by reset; contents never written are undefined.

Verification
REQ-034 WAIT=2: store word 0xDEADBEEF at 0x100, then word load 0x100 -> each rsp_valid 3 cycles after accept, load rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-035 After REQ-034: byte store 0x80 to 0x101, then signed byte load 0x101 -> 0xFFFFFF80; unsigned -> 0x00000080; word load 0x100 -> 0xDEAD80EF.
REQ-036 Halfword load 0x102 signed -> 0xFFFFDEAD; halfword load 0x101 -> rsp_err=1, rsp_rdata=0; word store 0x5 -> rsp_err=1, word at 0x4 unchanged.
REQ-037 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid, rsp_rdata, rsp_err constant, req_ready=0; new req_valid not accepted until handshake.
REQ-038 Reset pulse one cycle after accepting word store 0x12345678 at 0x200 -> no response; later load 0x200 returns prior value.
REQ-039 WAIT=0 and address 2^ADDR_W (0x100000) -> rsp_valid 1 cycle after accept with rsp_err=1.
